// File: rtl/regfile_multiport.sv
// Multi-port register file: N async read ports, two prioritised write ports, per-entry valid bits,
// sequenced clear sweep and collision flag. Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_multiport #(
    parameter int DATA_WIDTH         = 32,
    parameter int REGFILE_SIZE       = 128,
    parameter int REGFILE_ADDR_WIDTH = 7,
    parameter int NUM_RD_PORTS       = 2
) (
    input  logic                                     CLK_I,
    input  logic                                     RST_I,
    input  logic                                     EN_I,
    input  logic [NUM_RD_PORTS*REGFILE_ADDR_WIDTH-1:0] RD_ADDR_I,
    output logic [NUM_RD_PORTS*DATA_WIDTH-1:0]       RD_DATA_O,
    output logic [NUM_RD_PORTS-1:0]                  RD_VALID_O,
    input  logic                                     WR0_EN_I,
    input  logic [REGFILE_ADDR_WIDTH-1:0]            WR0_ADDR_I,
    input  logic [DATA_WIDTH-1:0]                    WR0_DATA_I,
    input  logic                                     WR1_EN_I,
    input  logic [REGFILE_ADDR_WIDTH-1:0]            WR1_ADDR_I,
    input  logic [DATA_WIDTH-1:0]                    WR1_DATA_I,
    input  logic                                     CLR_START_I,
    output logic                                     BUSY_O,
    output logic                                     COLLISION_O
);

    localparam int AW = REGFILE_ADDR_WIDTH;
    localparam int DW = DATA_WIDTH;
    localparam logic [AW:0]   SIZE_W   = (AW + 1)'(REGFILE_SIZE);
    localparam logic [AW-1:0] LAST_PTR = AW'(REGFILE_SIZE - 1);

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_e;

    state_e                  state_q, state_d;
    logic [AW-1:0]           ptr_q, ptr_d;
    logic                    busy_q, busy_d;
    logic                    collision_q, collision_d;
    logic [REGFILE_SIZE-1:0] valid_q, valid_d;
    logic [DW-1:0]           mem_q [REGFILE_SIZE];

    logic          wr0_ok, wr1_ok, clr_we;
    logic [AW-1:0] rd_addr;

    function automatic logic in_range(input logic [AW-1:0] addr);
        return {1'b0, addr} < SIZE_W;
    endfunction

    assign wr0_ok = EN_I && (state_q == ST_IDLE) && WR0_EN_I && in_range(WR0_ADDR_I);
    assign wr1_ok = EN_I && (state_q == ST_IDLE) && WR1_EN_I && in_range(WR1_ADDR_I);
    assign clr_we = EN_I && (state_q == ST_CLEAR);

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        valid_d     = valid_q;
        collision_d = 1'b0;
        if (EN_I) begin
            case (state_q)
                ST_IDLE: begin
                    if (wr0_ok) valid_d[WR0_ADDR_I] = 1'b1;
                    if (wr1_ok) valid_d[WR1_ADDR_I] = 1'b1;
                    collision_d = wr0_ok && wr1_ok && (WR0_ADDR_I == WR1_ADDR_I);
                    if (CLR_START_I) begin
                        state_d = ST_CLEAR;
                        ptr_d   = '0;
                    end
                end
                ST_CLEAR: begin
                    valid_d[ptr_q] = 1'b0;
                    if (ptr_q == LAST_PTR) begin
                        state_d = ST_IDLE;
                        ptr_d   = '0;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        busy_d = (state_d == ST_CLEAR);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            busy_q      <= 1'b0;
            collision_q <= 1'b0;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            busy_q      <= busy_d;
            collision_q <= collision_d;
            valid_q     <= valid_d;
        end
    end

    // NOTE: the data array is deliberately not reset; the valid bits alone decide what reads return.
    always_ff @(posedge CLK_I) begin
        if (clr_we) begin
            mem_q[ptr_q] <= '0;
        end else begin
            if (wr0_ok) mem_q[WR0_ADDR_I] <= WR0_DATA_I;
            // Later assignment wins, giving port 1 priority on an address clash.
            if (wr1_ok) mem_q[WR1_ADDR_I] <= WR1_DATA_I;
        end
    end

    always_comb begin
        RD_DATA_O  = '0;
        RD_VALID_O = '0;
        rd_addr    = '0;
        for (int k = 0; k < NUM_RD_PORTS; k++) begin
            rd_addr = RD_ADDR_I[k*AW +: AW];
            if (in_range(rd_addr) && valid_q[rd_addr]) begin
                RD_DATA_O[k*DW +: DW] = mem_q[rd_addr];
                RD_VALID_O[k]         = 1'b1;
            end
`ifdef REGFILE_BYPASS_EN
            if (wr1_ok && (WR1_ADDR_I == rd_addr)) begin
                RD_DATA_O[k*DW +: DW] = WR1_DATA_I;
                RD_VALID_O[k]         = 1'b1;
            end else if (wr0_ok && (WR0_ADDR_I == rd_addr)) begin
                RD_DATA_O[k*DW +: DW] = WR0_DATA_I;
                RD_VALID_O[k]         = 1'b1;
            end
`endif
        end
    end

    assign BUSY_O      = busy_q;
    assign COLLISION_O = collision_q;

endmodule

// File: tb/tb_regfile_multiport.sv
// Scoreboard bench for regfile_multiport: a driver pushes expected read/status values from an
// array-based reference model; a negedge monitor pops and compares them against the DUT.
module tb_regfile_multiport;

    localparam int SIZE = 128;

    logic        clk = 1'b0;
    logic        rst, en, wr0_en, wr1_en, clr;
    logic [6:0]  wr0_addr, wr1_addr;
    logic [31:0] wr0_data, wr1_data;
    logic [13:0] rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_valid;
    logic        busy, collision;

    int n_tests = 0;
    int n_fail  = 0;

    regfile_multiport dut (
        .CLK_I(clk), .RST_I(rst), .EN_I(en),
        .RD_ADDR_I(rd_addr), .RD_DATA_O(rd_data), .RD_VALID_O(rd_valid),
        .WR0_EN_I(wr0_en), .WR0_ADDR_I(wr0_addr), .WR0_DATA_I(wr0_data),
        .WR1_EN_I(wr1_en), .WR1_ADDR_I(wr1_addr), .WR1_DATA_I(wr1_data),
        .CLR_START_I(clr), .BUSY_O(busy), .COLLISION_O(collision)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0][6:0]  addr;
        logic [1:0][31:0] data;
        logic [1:0]       valid;
        logic             busy;
        logic             coll;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: plain arrays plus a "sweeping" flag and index.
    logic [31:0] m_mem [SIZE];
    bit          m_valid [SIZE];
    bit          m_clearing;
    int          m_idx;
    bit          m_coll;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < SIZE; i++) m_valid[i] = 1'b0;
        m_clearing = 1'b0;
        m_idx      = 0;
        m_coll     = 1'b0;
    endtask

    function automatic exp_t expect_now();
        exp_t e;
        logic [6:0] a;
        e = '0;
        for (int k = 0; k < 2; k++) begin
            a = rd_addr[k*7 +: 7];
            e.addr[k] = a;
            if (int'(a) < SIZE && m_valid[a]) begin
                e.data[k]  = m_mem[a];
                e.valid[k] = 1'b1;
            end
`ifdef REGFILE_BYPASS_EN
            if (en && !m_clearing) begin
                if (wr1_en && wr1_addr == a) begin
                    e.data[k]  = wr1_data;
                    e.valid[k] = 1'b1;
                end else if (wr0_en && wr0_addr == a) begin
                    e.data[k]  = wr0_data;
                    e.valid[k] = 1'b1;
                end
            end
`endif
        end
        e.busy = m_clearing;
        e.coll = m_coll;
        return e;
    endfunction

    task automatic model_edge();
        if (!en) begin
            m_coll = 1'b0;
        end else if (m_clearing) begin
            m_mem[m_idx]   = '0;
            m_valid[m_idx] = 1'b0;
            m_idx++;
            if (m_idx == SIZE) m_clearing = 1'b0;
            m_coll = 1'b0;
        end else begin
            m_coll = wr0_en && wr1_en && (wr0_addr == wr1_addr);
            if (wr0_en) begin m_mem[wr0_addr] = wr0_data; m_valid[wr0_addr] = 1'b1; end
            if (wr1_en) begin m_mem[wr1_addr] = wr1_data; m_valid[wr1_addr] = 1'b1; end
            if (clr) begin m_clearing = 1'b1; m_idx = 0; end
        end
    endtask

    // One clock: publish expectation for this cycle, take the edge, advance the model.
    task automatic step();
        exp_q.push_back(expect_now());
        @(posedge clk);
        if (!rst) model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        en = 1'b1; wr0_en = 1'b0; wr1_en = 1'b0; clr = 1'b0;
    endtask

    task automatic set_rd(input logic [6:0] a0, input logic [6:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic rand_writes(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            wr0_en = 1'b1; wr0_addr = 7'($urandom_range(0, 127)); wr0_data = $urandom;
            wr1_en = 1'b1; wr1_addr = 7'($urandom_range(0, 127)); wr1_data = $urandom;
            set_rd(7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)));
            step();
        end
        idle_inputs();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                for (int k = 0; k < 2; k++) begin
                    check($sformatf("rd_data%0d[%0d]", k, e.addr[k]), rd_data[k*32 +: 32], e.data[k]);
                    check($sformatf("rd_valid%0d[%0d]", k, e.addr[k]), 32'(rd_valid[k]), 32'(e.valid[k]));
                end
                check("busy", 32'(busy), 32'(e.busy));
                check("collision", 32'(collision), 32'(e.coll));
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        int n;
        rst = 1'b1;
        idle_inputs();
        wr0_addr = '0; wr1_addr = '0; wr0_data = '0; wr1_data = '0;
        for (int i = 0; i < SIZE; i++) m_mem[i] = '0;
        model_reset();
        set_rd(7'd0, 7'd127);
        @(posedge clk); #1;
        step();
        step();
        rst = 1'b0;
        step();

        // Two writes to different addresses, then read them back.
        wr0_en = 1'b1; wr0_addr = 7'd5; wr0_data = 32'h0000_00A5;
        wr1_en = 1'b1; wr1_addr = 7'd9; wr1_data = 32'hDEAD_BEEF;
        set_rd(7'd5, 7'd9);
        step();
        idle_inputs();
        step();

        // Same-address collision: port 1 must win, flag for one cycle.
        wr0_en = 1'b1; wr0_addr = 7'd3; wr0_data = 32'h11;
        wr1_en = 1'b1; wr1_addr = 7'd3; wr1_data = 32'h22;
        set_rd(7'd3, 7'd3);
        step();
        idle_inputs();
        step();
        step();

        // Same-cycle write/read of address 12.
        wr0_en = 1'b1; wr0_addr = 7'd12; wr0_data = 32'h55;
        set_rd(7'd5, 7'd12);
        step();
        idle_inputs();
        step();

        // Fill every entry with its index, then sweep.
        for (int i = 0; i < SIZE / 2; i++) begin
            wr0_en = 1'b1; wr0_addr = 7'(2*i);     wr0_data = 32'(2*i);
            wr1_en = 1'b1; wr1_addr = 7'(2*i + 1); wr1_data = 32'(2*i + 1);
            set_rd(7'(2*i), 7'($urandom_range(0, 127)));
            step();
        end
        idle_inputs();
        clr = 1'b1;
        step();
        clr = 1'b0;
        n = 0;
        while (busy && n < 400) begin
            wr0_en = (n == 5); wr0_addr = 7'd7; wr0_data = 32'h77;
            clr = (n == 9);
            set_rd(7'($urandom_range(0, 127)), 7'd7);
            step();
            n++;
        end
        idle_inputs();
        check("sweep_len", 32'(n), 32'd128);
        for (int i = 0; i < SIZE / 2; i++) begin
            set_rd(7'(2*i), 7'(2*i + 1));
            step();
        end

        // Sweep stalled by 10 disabled cycles.
        rand_writes(16);
        clr = 1'b1;
        step();
        clr = 1'b0;
        n = 0;
        while (busy && n < 400) begin
            en = !(n >= 20 && n < 30);
            set_rd(7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)));
            step();
            n++;
        end
        idle_inputs();
        check("stalled_sweep_len", 32'(n), 32'd138);

        // Reset 40 cycles into a sweep.
        rand_writes(200);
        clr = 1'b1;
        step();
        clr = 1'b0;
        for (int i = 0; i < 40; i++) begin
            set_rd(7'(i + 60), 7'(i + 80));
            step();
        end
        rst = 1'b1;
        model_reset();
        #1;
        check("busy_async_reset", 32'(busy), 32'd0);
        set_rd(7'd100, 7'd120);
        step();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            set_rd(7'(i * 16), 7'(i * 16 + 15));
            step();
        end

        // Randomised traffic over a narrow address range to provoke collisions and forwarding.
        for (int i = 0; i < 400; i++) begin
            en       = ($urandom_range(0, 9) != 0);
            wr0_en   = $urandom_range(0, 1) != 0;
            wr0_addr = 7'($urandom_range(0, 15));
            wr0_data = $urandom;
            wr1_en   = $urandom_range(0, 1) != 0;
            wr1_addr = 7'($urandom_range(0, 15));
            wr1_data = $urandom;
            clr      = ($urandom_range(0, 79) == 0);
            set_rd(7'($urandom_range(0, 15)), 7'($urandom_range(0, 15)));
            step();
        end
        idle_inputs();

        n = 0;
        while (exp_q.size() > 0 && n < 10) begin
            @(posedge clk);
            n++;
        end
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
